// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Shares one combinational ALU between two requesters. Requester 0 is the
//   integer execute path and requester 1 is the branch/address unit. One
//   operation is accepted at a time. Its operands and opcode are registered
//   onto the ALU and held for a per-opcode number of cycles, so multiply is
//   treated as multicycle. The ALU result and flags are then captured into a
//   one-cycle response.
//
// Handshake: a requester presents reqN_valid with a/b/op and holds them
//   stable until reqN_ready. reqN_ready is high only in IDLE, only for the
//   arbitration winner, and only while that requester is valid. A transfer
//   happens on a clock edge where valid && ready. At most one requester is
//   ready in any cycle.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   reqN_valid/ready/a/b/op      request channel for requester N (N = 0, 1)
//   alu_a, alu_b, alu_op         registered operands/opcode to the ALU
//   alu_result, alu_zero/carry/sign/ovf   ALU result and flags
//   rsp_valid                    one-cycle response strobe
//   rsp_id                       requester that owns the response
//   rsp_result, rsp_flags        captured result and {zero, carry, sign, ovf}
//   rsp_err                      opcode was 1000 or 1001 (unimplemented)
//   busy                         high while an operation is executing (EXEC)
module alu_scheduler #(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_sign,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Opcode 1000 makes the ALU output result 0 and flags 0. It is parked on
  // the ALU whenever no operation is executing.
  localparam logic [3:0] OP_DEFAULT = 4'b1000;
  localparam logic [3:0] ALU_HOLD   = 4'(ALU_LAT - 1);
  localparam logic [3:0] MUL_HOLD   = 4'(MUL_LAT - 1);

  state_t      state;
  logic        rr_ptr;     // requester favoured when both are valid
  logic        owner;      // requester of the operation in flight
  logic [3:0]  hold_cnt;   // remaining EXEC cycles after the current one

  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [3:0]        sel_op;
  logic              sel_is_mul;

  // Arbitration: a lone valid requester wins outright. When both are
  // valid, the round-robin pointer decides.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = rr_ptr;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_a      = grant ? req1_a  : req0_a;
  assign sel_b      = grant ? req1_b  : req0_b;
  assign sel_op     = grant ? req1_op : req0_op;
  // Opcodes 0010 and 0011 are the multiply variants.
  assign sel_is_mul = (sel_op[3:1] == 3'b001);

  assign busy = (state == EXEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      hold_cnt   <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_DEFAULT;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 4'd0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_op   <= sel_op;
            owner    <= grant;
            hold_cnt <= sel_is_mul ? MUL_HOLD : ALU_HOLD;
            rr_ptr   <= ~grant;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
          end else begin
            // Last EXEC cycle: the ALU has seen stable inputs for the full
            // hold time, so its outputs are captured here.
            rsp_valid  <= 1'b1;
            rsp_id     <= owner;
            rsp_result <= alu_result;
            rsp_flags  <= {alu_zero, alu_carry, alu_sign, alu_ovf};
            rsp_err    <= (alu_op[3:1] == 3'b100);
            alu_op     <= OP_DEFAULT;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler
//   Bench for alu_scheduler with default parameters (ALU_LAT=1, MUL_LAT=4).
//   A behavioural ALU drives the DUT's ALU inputs. The reference model keeps
//   the cycle at which the scheduler becomes free again, the favoured
//   requester, and a queue of expected responses with their due cycles.
module tb_alu_scheduler;

  localparam int DW      = 32;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req_a [2];
  logic [DW-1:0] req_b [2];
  logic [3:0]    req_op [2];
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic          alu_zero, alu_carry, alu_sign, alu_ovf;
  logic          rsp_valid, rsp_id, rsp_err, busy;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags;

  alu_scheduler #(.DATA_W(DW), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .req0_op    (req_op[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .req1_op    (req_op[1]),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .alu_sign   (alu_sign),
    .alu_ovf    (alu_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // ---------------- behavioural ALU ----------------
  // Returns {result, zero, carry, sign, ovf}. Opcodes 1000 and up give all zeros.
  function automatic logic [DW+3:0] alu_fn(input logic [3:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    logic          c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: begin
        s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; c = s[DW];
        v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      4'b0001: begin
        s = {1'b0, a} - {1'b0, b}; r = s[DW-1:0]; c = s[DW];
        v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      4'b0010: r = a * b;
      4'b0011: r = DW'($signed(a) * $signed(b));
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a << b[4:0];
      4'b0111: r = a ^ b;
      default: return '0;
    endcase
    return {r, (r == '0), c, r[DW-1], v};
  endfunction

  always_comb {alu_result, alu_zero, alu_carry, alu_sign, alu_ovf} = alu_fn(alu_op, alu_a, alu_b);

  // ---------------- check task ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // exp_q entry: {id, err, flags[3:0], result[DW-1:0]}
  logic [DW+5:0] exp_q[$];
  int            due_q[$];
  int            next_free = 0;   // first cycle in which the scheduler is idle again
  logic          favour    = 1'b0;
  logic [3:0]    cur_op;
  logic [DW-1:0] cur_a, cur_b;

  // observation logs used by the directed tests
  int            acc_id_q[$];
  int            acc_cyc_q[$];
  logic [DW-1:0] rsp_res_q[$];
  int            rsp_cnt = 0;
  int            rsp_cyc = 0;
  logic          last_id, last_err;
  logic [3:0]    last_flags;
  logic [DW-1:0] last_res;

  logic          m_idle, m_due, m_acc;
  int            m_gnt, m_id, m_lat;
  logic [DW+5:0] m_e;
  logic [DW+3:0] m_alu;

  always @(negedge clk) begin
    if (!rst) begin
      m_idle = (cyc >= next_free);
      chk("busy", busy, !m_idle);
      chk("ready_excl", req_ready[0] & req_ready[1], 0);
      // expected winner: lone requester, otherwise the one not granted last
      m_gnt = (req_valid[0] && req_valid[1]) ? int'(favour) : (req_valid[1] ? 1 : 0);
      chk("ready0", req_ready[0], m_idle && req_valid[0] && (m_gnt == 0));
      chk("ready1", req_ready[1], m_idle && req_valid[1] && (m_gnt == 1));
      if (!m_idle) begin
        chk("alu_op_hold", alu_op, cur_op);
        chk("alu_a_hold", alu_a, cur_a);
        chk("alu_b_hold", alu_b, cur_b);
      end else begin
        chk("alu_op_idle", alu_op, 4'b1000);
      end

      m_due = (due_q.size() != 0) && (due_q[0] == cyc);
      chk("rsp_valid", rsp_valid, m_due);
      if (m_due) begin
        m_e = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("rsp_id", rsp_id, m_e[DW+5]);
        chk("rsp_err", rsp_err, m_e[DW+4]);
        chk("rsp_flags", rsp_flags, m_e[DW+3:DW]);
        chk("rsp_result", rsp_result, m_e[DW-1:0]);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc    = cyc;
        last_id    = rsp_id;
        last_err   = rsp_err;
        last_flags = rsp_flags;
        last_res   = rsp_result;
        rsp_res_q.push_back(rsp_result);
      end

      m_acc = 1'b0;
      if (req_valid[0] && req_ready[0]) begin m_acc = 1'b1; m_id = 0; end
      else if (req_valid[1] && req_ready[1]) begin m_acc = 1'b1; m_id = 1; end
      if (m_acc) begin
        m_lat = (req_op[m_id] == 4'b0010 || req_op[m_id] == 4'b0011) ? MUL_LAT : ALU_LAT;
        m_alu = alu_fn(req_op[m_id], req_a[m_id], req_b[m_id]);
        exp_q.push_back({m_id[0], (req_op[m_id] == 4'b1000 || req_op[m_id] == 4'b1001),
                         m_alu[3:0], m_alu[DW+3:4]});
        due_q.push_back(cyc + m_lat + 1);
        next_free = cyc + m_lat + 1;
        favour    = ~m_id[0];
        cur_op    = req_op[m_id];
        cur_a     = req_a[m_id];
        cur_b     = req_b[m_id];
        acc_id_q.push_back(m_id);
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 4'b1000);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_err", rsp_err, 0);
    exp_q.delete();
    due_q.delete();
    next_free = 0;
    favour    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] op);
    bit got;
    got = 1'b0;
    req_a[id] = a; req_b[id] = b; req_op[id] = op; req_valid[id] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1'b1; break; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_id_q.delete();
    acc_cyc_q.delete();
    rsp_res_q.delete();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      default: return DW'($urandom);
    endcase
  endfunction

  // ---------------- test sequence ----------------
  int base;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 2; i++) begin req_a[i] = '0; req_b[i] = '0; req_op[i] = '0; end
    @(posedge clk); #1;
    do_reset();

    // 1: add 5 + 7 on requester 0
    clear_logs(); base = rsp_cnt;
    issue(0, 32'd5, 32'd7, 4'b0000);
    wait_drain();
    chk("t1_rsp_count", rsp_cnt - base, 1);
    chk("t1_latency", rsp_cyc - acc_cyc_q[0], 2);
    chk("t1_id", last_id, 0);
    chk("t1_result", last_res, 32'd12);
    chk("t1_flags", last_flags, 4'b0000);

    // 2: signed multiply on requester 1
    clear_logs(); base = rsp_cnt;
    issue(1, 32'd3, 32'hFFFF_FFFE, 4'b0011);
    wait_drain();
    chk("t2_rsp_count", rsp_cnt - base, 1);
    chk("t2_latency", rsp_cyc - acc_cyc_q[0], 5);
    chk("t2_id", last_id, 1);
    chk("t2_result", last_res, 32'hFFFF_FFFA);
    chk("t2_flags", last_flags, 4'b0010);

    // 3: both requesters continuously valid after reset
    do_reset();
    clear_logs();
    fork
      begin repeat (3) issue(0, DW'($urandom), DW'($urandom_range(0, 31)), 4'b0110); end
      begin repeat (3) issue(1, DW'($urandom), DW'($urandom_range(0, 31)), 4'b0110); end
    join
    wait_drain();
    chk("t3_count", acc_id_q.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), acc_id_q[i], i % 2);
    for (int i = 1; i < 6; i++) chk($sformatf("t3_gap%0d", i), acc_cyc_q[i] - acc_cyc_q[i-1], 2);

    // 4: back-to-back xor on requester 0
    clear_logs();
    issue(0, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'b0111);
    issue(0, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'b0111);
    wait_drain();
    chk("t4_count", rsp_res_q.size(), 2);
    chk("t4_gap", acc_cyc_q[1] - acc_cyc_q[0], 2);
    chk("t4_result0", rsp_res_q[0], 32'h0F0F_F0F0);
    chk("t4_result1", rsp_res_q[1], 32'h0F0F_F0F0);

    // 5: reset in the middle of a multiply
    clear_logs(); base = rsp_cnt;
    issue(0, 32'd9, 32'd9, 4'b0010);
    @(posedge clk); #1;
    do_reset();
    repeat (6) @(posedge clk); #1;
    chk("t5_no_rsp", rsp_cnt - base, 0);
    clear_logs();
    issue(1, 32'd1, 32'd2, 4'b0000);
    chk("t5_lone_req1", acc_id_q[0], 1);
    wait_drain();
    do_reset();
    clear_logs();
    fork
      issue(0, 32'd4, 32'd4, 4'b0100);
      issue(1, 32'd6, 32'd6, 4'b0101);
    join
    wait_drain();
    chk("t5_rr_after_reset", acc_id_q[0], 0);

    // 6: unimplemented opcode
    clear_logs(); base = rsp_cnt;
    issue(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'b1001);
    wait_drain();
    chk("t6_rsp_count", rsp_cnt - base, 1);
    chk("t6_err", last_err, 1);
    chk("t6_result", last_res, 0);
    chk("t6_flags", last_flags, 0);

    // randomized traffic from both requesters
    fork
      begin
        repeat (40) begin
          issue(0, rnd_data(), rnd_data(), 4'($urandom_range(0, 9)));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        repeat (40) begin
          issue(1, rnd_data(), rnd_data(), 4'($urandom_range(0, 9)));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    join
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
Sequencer and arbiter that shares the single combinational ALU between two requesters: requester 0 is the integer execute path and requester 1 is the branch/address unit.
It accepts one operation at a time through a valid/ready handshake and drives the registered operands and opcode onto the ALU. It holds them for a per-opcode number of cycles, so the multiply path is treated as multicycle. It then captures the result and flags into a one-cycle response.
It sits between the decode/execute logic and the ALU instance in the core.

Parameters:
DATA_W, 32, operand/result width (ALU is 32-bit; only 32 is supported)
ALU_LAT, 1, hold cycles for non-multiply opcodes (1..15)
MUL_LAT, 4, hold cycles for opcodes 4'b0010 and 4'b0011 (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  DATA_W  operand a, requester 0
req0_b  in  DATA_W  operand b, requester 0
req0_op  in  4  ALU opcode, requester 0
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
alu_a  out  DATA_W  registered operand a to ALU
alu_b  out  DATA_W  registered operand b to ALU
alu_op  out  4  registered opcode to ALU
alu_result  in  DATA_W  ALU result
alu_zero, alu_carry, alu_sign, alu_ovf  in  1 each  ALU flags
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  1  requester that owns the response
rsp_result  out  DATA_W  captured result
rsp_flags  out  4  captured {zero, carry, sign, ovf}
rsp_err  out  1  opcode was 4'b1000 or 4'b1001 (unimplemented)
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, any time) forces the following:
  - state = IDLE, rr_ptr = 0 (requester 0 favoured), hold counter = 0.
  - alu_a = alu_b = 0, alu_op = 4'b1000 (ALU default: result 0, flags 0).
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0, rsp_err = 0, busy = 0.
  - Any in-flight operation is abandoned with no response.
- States: IDLE and EXEC.
- IDLE, arbitration (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester selected by rr_ptr.
  - reqN_ready = (state==IDLE) && grant==N. Ready is never asserted for both requesters, and never outside IDLE.
- IDLE, accept (valid && ready at a clock edge):
  - Latch a, b and op into alu_a, alu_b and alu_op.
  - Latch the owner id.
  - Load hold counter with L-1, where L = MUL_LAT for op 0010/0011 and L = ALU_LAT otherwise.
  - Set rr_ptr to the id that was not granted.
  - Go to EXEC.
- EXEC:
  - alu_a, alu_b and alu_op are held stable.
  - The counter decrements each cycle while non-zero.
  - On the edge where the counter is 0, the block:
    - captures alu_result and the flags into rsp_*;
    - sets rsp_err = (op==1000 || op==1001);
    - sets rsp_id = owner and pulses rsp_valid for exactly one cycle;
    - returns alu_op to 4'b1000 and goes to IDLE.
- Timing:
  - Accept edge at cycle 0; EXEC occupies cycles 1..L; rsp_valid is high in cycle L+1.
  - In cycle L+1 the block is IDLE and may accept again. Peak throughput is one operation per L+1 cycles.
- rsp_* values other than rsp_valid hold their last values until the next capture.
- Requester protocol: valid, a, b and op must be held until ready. The scheduler does not check this; dropping valid before ready simply means nothing is accepted.
- Requests arriving while busy are stalled (ready low) and are never lost or reordered per requester.
- busy = (state==EXEC).
- The ALU is not re-registered internally; no other arithmetic is done here. Width of all data paths is DATA_W.

Test Plan:
1. req0 op 0000, a=5, b=7, ALU_LAT=1:
   - req0_ready high in cycle 0, busy high in cycle 1.
   - rsp_valid in cycle 2 with rsp_id=0, rsp_result=12, rsp_flags=4'b0000.
2. req1 op 0011, a=3, b=0xFFFFFFFE, MUL_LAT=4:
   - alu_op=0011 is stable in cycles 1..4.
   - rsp_valid in cycle 5 with rsp_id=1, rsp_result=0xFFFFFFFA, sign flag=1.
3. Both requesters assert valid continuously with op 0110, for 6 operations after reset:
   - Grant order is 0,1,0,1,0,1.
   - Each rsp_valid is followed the same cycle by the next ready.
   - Ready is never high for both requesters.
4. req0 holds valid with two back-to-back op 0111 operations (a=0xF0F0F0F0, b=0xFFFF0000), req1 idle:
   - Accepts occur in cycles 0 and 2.
   - Both results are 0x0F0FF0F0; each rsp_valid lasts one cycle.
5. Assert rst in cycle 2 of a MUL_LAT=4 multiply:
   - All outputs take their reset values immediately and alu_op=1000.
   - No rsp_valid is produced.
   - After reset release, req1 wins when only req1 is valid.
6. req0 op 1001:
   - rsp_valid in cycle 2 with rsp_err=1, rsp_result=0, rsp_flags=0.
